// File: rtl/cache_event_monitor.sv
// Observational performance monitor for CH data-cache channels: classifies accesses as
// read/write hits or misses, counts write-backs and miss stall cycles, registered readout.
module cache_event_monitor #(
   parameter int unsigned CH    = 1,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned SEL_W = 3
) (
   input  logic             clk_i,
   input  logic             start_i,
   input  logic [CH-1:0]    proc_read_i,
   input  logic [CH-1:0]    proc_write_i,
   input  logic [CH-1:0]    proc_stall_i,
   input  logic [CH-1:0]    ctrl_idle_i,
   input  logic [CH-1:0]    line_dirty_i,
   input  logic             clear_i,
   input  logic             freeze_i,
   input  logic [SEL_W-1:0] rd_ch_i,
   input  logic [2:0]       rd_ctr_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic [CH-1:0]    ovf_o
);

   localparam int unsigned NumCtr   = 6;
   localparam int unsigned CtrRh    = 0;
   localparam int unsigned CtrWh    = 1;
   localparam int unsigned CtrRm    = 2;
   localparam int unsigned CtrWm    = 3;
   localparam int unsigned CtrWb    = 4;
   localparam int unsigned CtrStall = 5;

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CntMax = '1;

   cnt_t                          cnt_q [CH][NumCtr];
   cnt_t                          cnt_d [CH][NumCtr];
   logic [CH-1:0]                 pend_q, pend_d;
   logic [CH-1:0]                 ovf_q, ovf_d;
   cnt_t                          rd_data_q, rd_data_d;
   logic [CH-1:0][NumCtr-1:0]     inc;

   // Per-channel classification; one increment request bit per counter.
   for (genvar g = 0; g < CH; g++) begin : g_cls
      logic acc, is_wr, miss_ev, hit_ev, done_ev;

      assign acc     = proc_read_i[g] | proc_write_i[g];
      assign is_wr   = proc_write_i[g];
      assign miss_ev = proc_stall_i[g] & ctrl_idle_i[g] & acc & ~pend_q[g];
      assign hit_ev  = ~proc_stall_i[g] & acc & ~pend_q[g];
      assign done_ev = ~proc_stall_i[g] & pend_q[g];

      assign inc[g][CtrRh]    = hit_ev & ~is_wr;
      assign inc[g][CtrWh]    = hit_ev & is_wr;
      assign inc[g][CtrRm]    = miss_ev & ~is_wr;
      assign inc[g][CtrWm]    = miss_ev & is_wr;
      assign inc[g][CtrWb]    = miss_ev & line_dirty_i[g];
      assign inc[g][CtrStall] = proc_stall_i[g] & (pend_q[g] | miss_ev);

      // pend tracks the miss even while frozen.
      always_comb begin
         pend_d[g] = pend_q[g];
         if (clear_i) begin
            pend_d[g] = 1'b0;
         end else if (miss_ev) begin
            pend_d[g] = 1'b1;
         end else if (done_ev) begin
            pend_d[g] = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clear_i) begin
         for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned k = 0; k < NumCtr; k++) begin
               cnt_d[c][k] = '0;
            end
         end
         ovf_d = '0;
      end else if (!freeze_i) begin
         for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned k = 0; k < NumCtr; k++) begin
               if (inc[c][k]) begin
                  if (cnt_q[c][k] == CntMax) begin
                     ovf_d[c] = 1'b1;
                  end else begin
                     cnt_d[c][k] = cnt_q[c][k] + 1'b1;
                  end
               end
            end
         end
      end
   end

   // Unmatched selects (channel >= CH, counter 6/7) fall through to zero.
   always_comb begin
      rd_data_d = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         for (int unsigned k = 0; k < NumCtr; k++) begin
            if (rd_ch_i == SEL_W'(c) && rd_ctr_i == 3'(k)) begin
               rd_data_d = cnt_q[c][k];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned k = 0; k < NumCtr; k++) begin
               cnt_q[c][k] <= '0;
            end
         end
         pend_q    <= '0;
         ovf_q     <= '0;
         rd_data_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_cache_event_monitor.sv
// Directed bench for cache_event_monitor (CH=4, CNT_W=8): hits, misses, stalls,
// saturation, clear, freeze, readout selects and asynchronous reset.
module tb_cache_event_monitor;

   localparam int unsigned CH    = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned SEL_W = 3;

   localparam int RH = 0, WH = 1, RM = 2, WM = 3, WB = 4, ST = 5;

   logic             clk_i = 1'b0;
   logic             start_i;
   logic [CH-1:0]    proc_read_i, proc_write_i, proc_stall_i, ctrl_idle_i, line_dirty_i;
   logic             clear_i, freeze_i;
   logic [SEL_W-1:0] rd_ch_i;
   logic [2:0]       rd_ctr_i;
   logic [CNT_W-1:0] rd_data_o;
   logic [CH-1:0]    ovf_o;

   int vectors    = 0;
   int miscompares = 0;

   cache_event_monitor #(
      .CH    (CH),
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
   ) dut (
      .clk_i        (clk_i),
      .start_i      (start_i),
      .proc_read_i  (proc_read_i),
      .proc_write_i (proc_write_i),
      .proc_stall_i (proc_stall_i),
      .ctrl_idle_i  (ctrl_idle_i),
      .line_dirty_i (line_dirty_i),
      .clear_i      (clear_i),
      .freeze_i     (freeze_i),
      .rd_ch_i      (rd_ch_i),
      .rd_ctr_i     (rd_ctr_i),
      .rd_data_o    (rd_data_o),
      .ovf_o        (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      proc_read_i  = '0;
      proc_write_i = '0;
      proc_stall_i = '0;
      ctrl_idle_i  = '0;
      line_dirty_i = '0;
   endtask

   // Select a counter, let one edge register it, then compare.
   task automatic chk_ctr(input string tag, input int ch, input int ctr, input int exp);
      rd_ch_i  = 3'(ch);
      rd_ctr_i = 3'(ctr);
      tick();
      check($sformatf("%s ch%0d ctr%0d", tag, ch, ctr), 32'(rd_data_o), 32'(exp));
   endtask

   initial begin
      idle();
      start_i  = 1'b0;
      clear_i  = 1'b0;
      freeze_i = 1'b0;
      rd_ch_i  = '0;
      rd_ctr_i = '0;

      // Reset held for 3 cycles, then full select sweep.
      ticks(3);
      check("reset rd_data", 32'(rd_data_o), 32'd0);
      check("reset ovf", 32'(ovf_o), 32'd0);
      start_i = 1'b1;
      tick();
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 8; k++) chk_ctr("reset sweep", c, k, 0);
      end
      check("reset sweep ovf", 32'(ovf_o), 32'd0);

      // ch0: 4 read hits, 2 write hits, 1 read+write treated as write.
      proc_read_i[0] = 1'b1;
      ticks(4);
      proc_read_i[0]  = 1'b0;
      proc_write_i[0] = 1'b1;
      ticks(2);
      proc_read_i[0] = 1'b1;
      tick();
      idle();
      chk_ctr("hits", 0, RH, 4);
      chk_ctr("hits", 0, WH, 3);
      chk_ctr("hits", 0, RM, 0);
      chk_ctr("hits", 0, WM, 0);
      chk_ctr("hits", 0, WB, 0);
      chk_ctr("hits", 0, ST, 0);
      chk_ctr("hits other ch", 1, RH, 0);

      // Read miss, dirty victim, 6 stall cycles then completion with read still high.
      proc_read_i[0]  = 1'b1;
      proc_stall_i[0] = 1'b1;
      ctrl_idle_i[0]  = 1'b1;
      line_dirty_i[0] = 1'b1;
      tick();
      ctrl_idle_i[0]  = 1'b0;
      line_dirty_i[0] = 1'b0;
      ticks(5);
      proc_stall_i[0] = 1'b0;
      ctrl_idle_i[0]  = 1'b1;
      tick();
      idle();
      chk_ctr("rmiss", 0, RM, 1);
      chk_ctr("rmiss", 0, WB, 1);
      chk_ctr("rmiss", 0, ST, 6);
      chk_ctr("rmiss no hit", 0, RH, 4);
      proc_read_i[0] = 1'b1;
      tick();
      idle();
      chk_ctr("hit after miss", 0, RH, 5);

      // Stall without idle and without pend counts nothing; the following hit counts.
      proc_read_i[0]  = 1'b1;
      proc_stall_i[0] = 1'b1;
      ticks(2);
      proc_stall_i[0] = 1'b0;
      tick();
      idle();
      chk_ctr("stall no idle", 0, ST, 6);
      chk_ctr("stall no idle", 0, RM, 1);
      chk_ctr("stall no idle", 0, RH, 6);

      // ch2 write miss (clean) concurrent with ch0 read hits.
      proc_read_i[0]  = 1'b1;
      proc_write_i[2] = 1'b1;
      proc_stall_i[2] = 1'b1;
      ctrl_idle_i[2]  = 1'b1;
      tick();
      ctrl_idle_i[2] = 1'b0;
      ticks(2);
      proc_stall_i[2] = 1'b0;
      tick();
      idle();
      chk_ctr("multi", 2, WM, 1);
      chk_ctr("multi", 2, WB, 0);
      chk_ctr("multi", 2, ST, 3);
      chk_ctr("multi", 2, WH, 0);
      chk_ctr("multi", 0, RH, 10);
      for (int k = 0; k < 6; k++) begin
         chk_ctr("multi idle", 1, k, 0);
         chk_ctr("multi idle", 3, k, 0);
      end
      chk_ctr("sel ch out of range", 5, RH, 0);
      chk_ctr("sel ctr 6", 0, 6, 0);
      chk_ctr("sel ctr 7", 2, 7, 0);

      // Saturation: RH 10 -> 255 after 245 hits, ovf on the next attempt.
      proc_read_i[0] = 1'b1;
      ticks(245);
      idle();
      chk_ctr("sat edge", 0, RH, 255);
      check("sat edge ovf", 32'(ovf_o), 32'd0);
      proc_read_i[0] = 1'b1;
      tick();
      idle();
      check("sat ovf set", 32'(ovf_o), 32'b0001);
      proc_read_i[0] = 1'b1;
      ticks(14);
      idle();
      chk_ctr("sat hold", 0, RH, 255);
      check("sat ovf sticky", 32'(ovf_o), 32'b0001);

      // Clear with a concurrent hit: the hit is lost.
      clear_i        = 1'b1;
      proc_read_i[0] = 1'b1;
      tick();
      clear_i = 1'b0;
      idle();
      chk_ctr("clear", 0, RH, 0);
      chk_ctr("clear", 2, WM, 0);
      check("clear ovf", 32'(ovf_o), 32'd0);

      // Freeze during 3 hits, then 2 hits counted.
      freeze_i       = 1'b1;
      proc_read_i[0] = 1'b1;
      ticks(3);
      freeze_i = 1'b0;
      ticks(2);
      idle();
      chk_ctr("freeze", 0, RH, 2);

      // Miss starting under freeze, completion after release: nothing counted.
      freeze_i        = 1'b1;
      proc_read_i[0]  = 1'b1;
      proc_stall_i[0] = 1'b1;
      ctrl_idle_i[0]  = 1'b1;
      tick();
      ctrl_idle_i[0] = 1'b0;
      tick();
      freeze_i        = 1'b0;
      proc_stall_i[0] = 1'b0;
      tick();
      idle();
      chk_ctr("frozen miss", 0, RM, 0);
      chk_ctr("frozen miss", 0, ST, 0);
      chk_ctr("frozen miss no hit", 0, RH, 2);
      proc_read_i[0] = 1'b1;
      tick();
      idle();
      chk_ctr("hit after frozen miss", 0, RH, 3);

      // Async reset mid-miss: readout clears immediately, pend is lost.
      proc_read_i[0]  = 1'b1;
      proc_stall_i[0] = 1'b1;
      ctrl_idle_i[0]  = 1'b1;
      tick();
      ctrl_idle_i[0] = 1'b0;
      check("pre-reset rd_data", 32'(rd_data_o), 32'd3);
      start_i = 1'b0;
      #1;
      check("async reset rd_data", 32'(rd_data_o), 32'd0);
      tick();
      start_i = 1'b1;
      tick();
      proc_stall_i[0] = 1'b0;
      tick();
      idle();
      chk_ctr("post reset", 0, RM, 0);
      chk_ctr("post reset", 0, ST, 0);
      chk_ctr("post reset hit", 0, RH, 1);
      check("post reset ovf", 32'(ovf_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_event_monitor.md
# cache_event_monitor

Synthesizable, parametrised performance monitor for the data-cache subsystem. It snoops CH independent cache/processor interfaces and classifies each access as a read/write hit or miss with the classification rules the CPU cache bench uses, counts write-backs and miss stall cycles, and exposes every counter through a registered select/readout port. It sits beside the cache instances inside CPU and is purely observational: it drives nothing back into the cache or memory path.

## Interface
- CH, default 1: number of monitored cache channels, range 1..8.
- CNT_W, default 32: width of every counter, range 8..32.
- SEL_W, default 3: width of rd_ch_i, range 1..3; must satisfy 2^SEL_W >= CH.

- clk_i, input, 1: clock. All logic is on the rising edge.
- start_i, input, 1: reset, asynchronous, active-low.
- proc_read_i, input, CH: per-channel processor read request.
- proc_write_i, input, CH: per-channel processor write request.
- proc_stall_i, input, CH: per-channel cache stall to the processor.
- ctrl_idle_i, input, CH: per-channel cache controller is in its idle/compare state.
- line_dirty_i, input, CH: per-channel indexed line is valid and dirty.
- clear_i, input, 1: synchronous clear of all counters and flags.
- freeze_i, input, 1: hold all counters. Classification flags keep tracking.
- rd_ch_i, input, SEL_W: readout channel select.
- rd_ctr_i, input, 3: readout counter select. 0 RH, 1 WH, 2 RM, 3 WM, 4 WB, 5 STALL. 6 and 7 read as 0.
- rd_data_o, output, CNT_W: registered readout.
- ovf_o, output, CH: sticky per-channel saturation flag.

## Operation
Each channel has one flag, pend, and six counters. Definitions per channel, per clock:
- access = read | write. If read and write are asserted together, the access is treated as a write.
- miss_ev = stall & idle & access & !pend.
  - On miss_ev, pend is set to 1.
  - WM increments if write, otherwise RM increments.
  - WB also increments if dirty is high.
- While stall & pend, STALL increments every cycle, including the miss_ev cycle.
- When !stall & pend: this is the completion cycle. No hit is counted and pend is cleared.
- hit_ev = !stall & access & !pend. WH increments if write, otherwise RH increments.
- Stall without idle and without pend (for example stalled in a memory state before any idle cycle is seen): nothing is counted.

Counter rules:
- Counters saturate at 2^CNT_W-1 and never wrap.
- The first increment attempt on a saturated counter sets ovf_o[ch], which stays set until clear or reset.
- freeze_i=1 blocks all counter increments and ovf updates. pend still updates.
- clear_i=1 zeroes all counters, pend and ovf_o that edge and overrides any event in the same cycle. The events of that cycle are lost.

Readout:
- rd_data_o <= counter[rd_ch_i][rd_ctr_i], sampled at the same edge the counter updates, so it shows the pre-update value.
- rd_ch_i >= CH returns 0.
- Readout stays live during freeze.

## Timing
- Reset (start_i low, asynchronous): rd_data_o=0, ovf_o=0, all counters=0, pend=0. Outputs are held while start_i stays low.
- Reset asserted in the middle of a miss: pend is lost. The first cycle after release is classified afresh.
- Event to counter visible: 1 cycle.
- Select to rd_data_o: 1 cycle.
- Counter update to rd_data_o: 2 cycles worst case.
- A miss spanning N stall cycles followed by 1 completion cycle produces:
  - 1 miss count,
  - N STALL counts,
  - 0 hit counts.
- Back-to-back hits: one count per cycle.
- A hit on the cycle after the completion cycle is counted normally.
- Channels are fully independent. There is no arbitration and all channels can update in the same cycle.

## Test plan
- Reset with start_i low for 3 cycles, then sweep all selects → rd_data_o=0 for every channel and counter, ovf_o=0.
- CH=1: read with stall=0 for 4 cycles, then write for 2 cycles → RH=4, WH=2, all others 0.
- Read miss: stall=1, idle=1, dirty=1 on cycle 0; stall=1, idle=0 on cycles 1-5; stall=0, read=1 on cycle 6 → RM=1, WB=1, STALL=6, RH=0. A read on cycle 7 gives RH=1.
- CH=4: channel 2 write miss (dirty=0) concurrent with channel 0 read hits → ch2 WM=1, WB=0; ch0 RH counts every cycle; ch1 and ch3 all 0.
- CNT_W=8: 260 read hits → RH=255, ovf_o[0]=1. Then pulse clear_i with a concurrent hit → RH=0, ovf_o=0.
- freeze_i during 3 hits, then release and 2 more hits → RH=2. A miss whose stall starts during freeze and whose completion arrives after release: no miss counted, and the completion cycle is not counted as a hit.
